// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ID/EX operand-stage signal bundle (decode in, M/W bypass in, EX out)
interface ex_operand_stage_if #(
  parameter int N = 32
);
  // decode-stage instruction
  logic         ValidD;
  logic [N-1:0] RD1D;
  logic [N-1:0] RD2D;
  logic [N-1:0] ImmExtD;
  logic [N-1:0] PCD;
  logic [4:0]   Rs1D;
  logic [4:0]   Rs2D;
  logic [4:0]   RdD;
  logic [2:0]   ALUControlD;
  logic         ALUSrcD;
  logic         RegWriteD;
  logic         MemWriteD;
  logic         BranchD;
  logic [1:0]   ResultSrcD;
  // bypass sources from later stages
  logic [4:0]   RdM;
  logic         RegWriteM;
  logic [N-1:0] ALUResultM;
  logic [4:0]   RdW;
  logic         RegWriteW;
  logic [N-1:0] ResultW;
  logic         PCSrcE;
  // EX-stage outputs
  logic [N-1:0] SrcAE;
  logic [N-1:0] SrcBE;
  logic [2:0]   ALUControlE;
  logic [N-1:0] WriteDataE;
  logic [N-1:0] PCTargetE;
  logic [4:0]   RdE;
  logic         RegWriteE;
  logic         MemWriteE;
  logic         BranchE;
  logic         ValidE;
  logic         IllegalE;
  logic [1:0]   ResultSrcE;
  // hazard controls
  logic         StallF;
  logic         StallD;
  logic         FlushD;

  modport master (
    output ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD,
           RegWriteD, MemWriteD, BranchD, ResultSrcD,
           RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW, PCSrcE,
    input  SrcAE, SrcBE, ALUControlE, WriteDataE, PCTargetE, RdE, RegWriteE, MemWriteE,
           BranchE, ValidE, IllegalE, ResultSrcE, StallF, StallD, FlushD
  );

  modport slave (
    input  ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD, ALUControlD, ALUSrcD,
           RegWriteD, MemWriteD, BranchD, ResultSrcD,
           RdM, RegWriteM, ALUResultM, RdW, RegWriteW, ResultW, PCSrcE,
    output SrcAE, SrcBE, ALUControlE, WriteDataE, PCTargetE, RdE, RegWriteE, MemWriteE,
           BranchE, ValidE, IllegalE, ResultSrcE, StallF, StallD, FlushD
  );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with M/W forwarding, branch target and load-use hazard control
module ex_operand_stage #(
  parameter int N = 32
) (
  input  logic clk,
  input  logic reset,
  ex_operand_stage_if.slave bus
);

  logic         valid_e_q,       valid_e_d;
  logic         illegal_e_q,     illegal_e_d;
  logic         reg_write_e_q,   reg_write_e_d;
  logic         mem_write_e_q,   mem_write_e_d;
  logic         branch_e_q,      branch_e_d;
  logic         alu_src_e_q,     alu_src_e_d;
  logic [1:0]   result_src_e_q,  result_src_e_d;
  logic [2:0]   alu_control_e_q, alu_control_e_d;
  logic [4:0]   rs1_e_q,         rs1_e_d;
  logic [4:0]   rs2_e_q,         rs2_e_d;
  logic [4:0]   rd_e_q,          rd_e_d;
  logic [N-1:0] rd1_e_q,         rd1_e_d;
  logic [N-1:0] rd2_e_q,         rd2_e_d;
  logic [N-1:0] imm_e_q,         imm_e_d;
  logic [N-1:0] pc_e_q,          pc_e_d;

  logic         lw_stall;
  logic         flush_e;
  logic         illegal_d;
  logic [N-1:0] fwd_a;
  logic [N-1:0] fwd_b;

  // Load-use detection against the instruction now in EX; a taken branch overrides the stall.
  always_comb begin
    lw_stall = bus.ValidD && (result_src_e_q == 2'b01) && (rd_e_q != 5'd0) &&
               ((bus.Rs1D == rd_e_q) || (bus.Rs2D == rd_e_q));
    flush_e  = lw_stall || bus.PCSrcE;
  end

  assign bus.StallF = lw_stall && !bus.PCSrcE;
  assign bus.StallD = lw_stall && !bus.PCSrcE;
  assign bus.FlushD = bus.PCSrcE;

  // Next EX contents: a bubble on flush, otherwise the decode slot with illegal ops neutralised.
  always_comb begin
    illegal_d       = bus.ValidD && bus.ALUControlD[2];
    valid_e_d       = 1'b0;
    illegal_e_d     = 1'b0;
    reg_write_e_d   = 1'b0;
    mem_write_e_d   = 1'b0;
    branch_e_d      = 1'b0;
    alu_src_e_d     = 1'b0;
    result_src_e_d  = 2'b00;
    alu_control_e_d = 3'b000;
    rs1_e_d         = 5'd0;
    rs2_e_d         = 5'd0;
    rd_e_d          = 5'd0;
    rd1_e_d         = '0;
    rd2_e_d         = '0;
    imm_e_d         = '0;
    pc_e_d          = '0;
    if (!flush_e) begin
      valid_e_d       = bus.ValidD;
      illegal_e_d     = illegal_d;
      reg_write_e_d   = bus.RegWriteD && !illegal_d;
      mem_write_e_d   = bus.MemWriteD && !illegal_d;
      branch_e_d      = bus.BranchD && !illegal_d;
      alu_src_e_d     = bus.ALUSrcD;
      result_src_e_d  = bus.ResultSrcD;
      alu_control_e_d = illegal_d ? 3'b000 : bus.ALUControlD;
      rs1_e_d         = bus.Rs1D;
      rs2_e_d         = bus.Rs2D;
      rd_e_d          = bus.RdD;
      rd1_e_d         = bus.RD1D;
      rd2_e_d         = bus.RD2D;
      imm_e_d         = bus.ImmExtD;
      pc_e_d          = bus.PCD;
    end
  end

  // D->E pipeline register; reset produces the same all-zero bubble as a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_e_q       <= 1'b0;
      illegal_e_q     <= 1'b0;
      reg_write_e_q   <= 1'b0;
      mem_write_e_q   <= 1'b0;
      branch_e_q      <= 1'b0;
      alu_src_e_q     <= 1'b0;
      result_src_e_q  <= 2'b00;
      alu_control_e_q <= 3'b000;
      rs1_e_q         <= 5'd0;
      rs2_e_q         <= 5'd0;
      rd_e_q          <= 5'd0;
      rd1_e_q         <= '0;
      rd2_e_q         <= '0;
      imm_e_q         <= '0;
      pc_e_q          <= '0;
    end else begin
      valid_e_q       <= valid_e_d;
      illegal_e_q     <= illegal_e_d;
      reg_write_e_q   <= reg_write_e_d;
      mem_write_e_q   <= mem_write_e_d;
      branch_e_q      <= branch_e_d;
      alu_src_e_q     <= alu_src_e_d;
      result_src_e_q  <= result_src_e_d;
      alu_control_e_q <= alu_control_e_d;
      rs1_e_q         <= rs1_e_d;
      rs2_e_q         <= rs2_e_d;
      rd_e_q          <= rd_e_d;
      rd1_e_q         <= rd1_e_d;
      rd2_e_q         <= rd2_e_d;
      imm_e_q         <= imm_e_d;
      pc_e_q          <= pc_e_d;
    end
  end

  // Operand bypass: MEM beats WB, and x0 always reads the register-file value.
  always_comb begin
    fwd_a = rd1_e_q;
    if (bus.RegWriteM && (bus.RdM == rs1_e_q) && (rs1_e_q != 5'd0)) begin
      fwd_a = bus.ALUResultM;
    end else if (bus.RegWriteW && (bus.RdW == rs1_e_q) && (rs1_e_q != 5'd0)) begin
      fwd_a = bus.ResultW;
    end
    fwd_b = rd2_e_q;
    if (bus.RegWriteM && (bus.RdM == rs2_e_q) && (rs2_e_q != 5'd0)) begin
      fwd_b = bus.ALUResultM;
    end else if (bus.RegWriteW && (bus.RdW == rs2_e_q) && (rs2_e_q != 5'd0)) begin
      fwd_b = bus.ResultW;
    end
  end

  assign bus.SrcAE       = fwd_a;
  assign bus.WriteDataE  = fwd_b;
  assign bus.SrcBE       = alu_src_e_q ? imm_e_q : fwd_b;
  assign bus.PCTargetE   = pc_e_q + imm_e_q;
  assign bus.ALUControlE = alu_control_e_q;
  assign bus.RdE         = rd_e_q;
  assign bus.RegWriteE   = reg_write_e_q;
  assign bus.MemWriteE   = mem_write_e_q;
  assign bus.BranchE     = branch_e_q;
  assign bus.ValidE      = valid_e_q;
  assign bus.IllegalE    = illegal_e_q;
  assign bus.ResultSrcE  = result_src_e_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - random plus directed checks of ex_operand_stage against a behavioural model
module tb_ex_operand_stage;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  ex_operand_stage_if #(.N(32)) bus ();

  ex_operand_stage #(.N(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The instruction the model believes occupies EX.
  typedef struct packed {
    logic        valid;
    logic        ill;
    logic        rw;
    logic        mw;
    logic        br;
    logic        asrc;
    logic [1:0]  rsrc;
    logic [2:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
  } ex_t;

  ex_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit load_use();
    return bus.ValidD && m.rsrc == 2'b01 && m.rd != 0 &&
           (bus.Rs1D == m.rd || bus.Rs2D == m.rd);
  endfunction

  // Value an EX source register must read once later-stage writes are considered.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regval);
    if (idx == 0) return regval;
    if (bus.RegWriteM && bus.RdM == idx) return bus.ALUResultM;
    if (bus.RegWriteW && bus.RdW == idx) return bus.ResultW;
    return regval;
  endfunction

  function automatic ex_t next_ex();
    ex_t n;
    n = '0;
    if (reset || load_use() || bus.PCSrcE) return n;
    n.valid = bus.ValidD;
    n.asrc  = bus.ALUSrcD;
    n.rsrc  = bus.ResultSrcD;
    n.rs1   = bus.Rs1D;
    n.rs2   = bus.Rs2D;
    n.rd    = bus.RdD;
    n.rd1   = bus.RD1D;
    n.rd2   = bus.RD2D;
    n.imm   = bus.ImmExtD;
    n.pc    = bus.PCD;
    if (bus.ValidD && bus.ALUControlD[2]) begin
      n.ill = 1'b1;
    end else begin
      n.alu = bus.ALUControlD;
      n.rw  = bus.RegWriteD;
      n.mw  = bus.MemWriteD;
      n.br  = bus.BranchD;
    end
    return n;
  endfunction

  // Model advance on each rising edge.
  always @(posedge clk) m <= next_ex();

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] wd;
      bit lw;
      wd = fwd(m.rs2, m.rd2);
      lw = load_use();
      chk("SrcAE", bus.SrcAE, fwd(m.rs1, m.rd1));
      chk("WriteDataE", bus.WriteDataE, wd);
      chk("SrcBE", bus.SrcBE, m.asrc ? m.imm : wd);
      chk("PCTargetE", bus.PCTargetE, m.pc + m.imm);
      chk("ALUControlE", 32'(bus.ALUControlE), 32'(m.alu));
      chk("RdE", 32'(bus.RdE), 32'(m.rd));
      chk("ctrlE", {26'd0, bus.ValidE, bus.IllegalE, bus.RegWriteE, bus.MemWriteE, bus.BranchE, 1'b0},
          {26'd0, m.valid, m.ill, m.rw, m.mw, m.br, 1'b0});
      chk("ResultSrcE", 32'(bus.ResultSrcE), 32'(m.rsrc));
      chk("StallF", 32'(bus.StallF), 32'(lw && !bus.PCSrcE));
      chk("StallD", 32'(bus.StallD), 32'(lw && !bus.PCSrcE));
      chk("FlushD", 32'(bus.FlushD), 32'(bus.PCSrcE));
    end
  end

  task automatic clr();
    bus.ValidD = 0; bus.RD1D = 0; bus.RD2D = 0; bus.ImmExtD = 0; bus.PCD = 0;
    bus.Rs1D = 0; bus.Rs2D = 0; bus.RdD = 0; bus.ALUControlD = 0; bus.ALUSrcD = 0;
    bus.RegWriteD = 0; bus.MemWriteD = 0; bus.BranchD = 0; bus.ResultSrcD = 0;
    bus.RdM = 0; bus.RegWriteM = 0; bus.ALUResultM = 0;
    bus.RdW = 0; bus.RegWriteW = 0; bus.ResultW = 0; bus.PCSrcE = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    bus.ValidD = 1; bus.RegWriteD = 1; bus.RdD = 5'd7; bus.PCD = 32'h40; bus.ImmExtD = 32'h8;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst RegWriteE", 32'(bus.RegWriteE), 32'd0);
    chk("rst RdE", 32'(bus.RdE), 32'd0);
    chk("rst ValidE", 32'(bus.ValidE), 32'd0);
    chk("rst PCTargetE", bus.PCTargetE, 32'd0);
    chk("rst StallF", 32'(bus.StallF), 32'd0);
    reset = 1'b0;

    // forwarding priority
    clr(); bus.ValidD = 1; bus.RD1D = 32'd5; bus.Rs1D = 5'd3;
    tick();
    bus.RdM = 5'd3; bus.ALUResultM = 32'h11; bus.RegWriteM = 1;
    bus.RdW = 5'd3; bus.ResultW = 32'h22; bus.RegWriteW = 1;
    #1 chk("fwd M prio", bus.SrcAE, 32'h11);
    bus.RegWriteM = 0;
    #1 chk("fwd W", bus.SrcAE, 32'h22);
    bus.Rs1D = 5'd0; bus.RdM = 5'd0; bus.RegWriteM = 1;
    tick();
    chk("fwd x0", bus.SrcAE, 32'd5);

    // immediate select
    clr(); bus.ValidD = 1; bus.ALUSrcD = 1; bus.ImmExtD = 32'hFFFF_FFFC; bus.RD2D = 32'd7;
    tick();
    chk("imm SrcBE", bus.SrcBE, 32'hFFFF_FFFC);
    chk("imm WriteDataE", bus.WriteDataE, 32'd7);

    // load-use stall then W forwarding
    clr(); bus.ValidD = 1; bus.ResultSrcD = 2'b01; bus.RdD = 5'd5; bus.RegWriteD = 1;
    tick();
    clr(); bus.ValidD = 1; bus.Rs2D = 5'd5; bus.RdD = 5'd6; bus.RegWriteD = 1;
    #1 chk("lu StallF", 32'(bus.StallF), 32'd1);
    chk("lu StallD", 32'(bus.StallD), 32'd1);
    chk("lu FlushD", 32'(bus.FlushD), 32'd0);
    tick();
    chk("lu bubble", 32'(bus.ValidE), 32'd0);
    chk("lu StallF drop", 32'(bus.StallF), 32'd0);
    bus.RdW = 5'd5; bus.ResultW = 32'h99; bus.RegWriteW = 1;
    tick();
    chk("lu SrcBE", bus.SrcBE, 32'h99);
    chk("lu ValidE", 32'(bus.ValidE), 32'd1);

    // branch flush overrides stall; target wraps
    clr(); bus.ValidD = 1; bus.ResultSrcD = 2'b01; bus.RdD = 5'd5;
    tick();
    clr(); bus.ValidD = 1; bus.Rs1D = 5'd5; bus.PCSrcE = 1;
    #1 chk("br FlushD", 32'(bus.FlushD), 32'd1);
    chk("br StallF", 32'(bus.StallF), 32'd0);
    chk("br StallD", 32'(bus.StallD), 32'd0);
    tick();
    chk("br bubble", 32'(bus.ValidE), 32'd0);
    clr(); bus.ValidD = 1; bus.PCD = 32'hFFFF_FFF0; bus.ImmExtD = 32'h20;
    tick();
    chk("br target wrap", bus.PCTargetE, 32'h10);

    // illegal op
    clr(); bus.ValidD = 1; bus.ALUControlD = 3'b101; bus.RegWriteD = 1;
    tick();
    chk("ill ALUControlE", 32'(bus.ALUControlE), 32'd0);
    chk("ill IllegalE", 32'(bus.IllegalE), 32'd1);
    chk("ill RegWriteE", 32'(bus.RegWriteE), 32'd0);
    clr(); bus.ValidD = 1; bus.ALUControlD = 3'b001; bus.RegWriteD = 1;
    tick();
    chk("ill clears", 32'(bus.IllegalE), 32'd0);
    chk("legal ALUControlE", 32'(bus.ALUControlE), 32'd1);

    // randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.ValidD     = ($urandom_range(0, 7) != 0);
      bus.RD1D       = $urandom;
      bus.RD2D       = $urandom;
      bus.ImmExtD    = $urandom;
      bus.PCD        = $urandom;
      bus.Rs1D       = 5'($urandom_range(0, 3));
      bus.Rs2D       = 5'($urandom_range(0, 3));
      bus.RdD        = 5'($urandom_range(0, 3));
      bus.ALUControlD = 3'($urandom_range(0, 7));
      bus.ALUSrcD    = 1'($urandom_range(0, 1));
      bus.RegWriteD  = 1'($urandom_range(0, 1));
      bus.MemWriteD  = 1'($urandom_range(0, 1));
      bus.BranchD    = 1'($urandom_range(0, 1));
      bus.ResultSrcD = 2'($urandom_range(0, 3));
      bus.RdM        = 5'($urandom_range(0, 3));
      bus.RegWriteM  = 1'($urandom_range(0, 1));
      bus.ALUResultM = $urandom;
      bus.RdW        = 5'($urandom_range(0, 3));
      bus.RegWriteW  = 1'($urandom_range(0, 1));
      bus.ResultW    = $urandom;
      bus.PCSrcE     = ($urandom_range(0, 7) == 0);
      tick();
    end

    reset = 1'b0;
    clr();
    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
